// File: rtl/vram_pkg.sv
// Shared types and default widths for the video SRAM arbiter and the scanout fetch unit.
package vram_pkg;

  localparam int unsigned VramAddrW = 18;
  localparam int unsigned VramDataW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StDisp,
    StCpu,
    StTurn
  } arb_state_e;

  // Which requester, if any, owns the read currently on the SRAM pins.
  typedef enum logic [1:0] {
    OwnNone,
    OwnDisp,
    OwnCpu
  } owner_e;

endpackage

// File: rtl/vram_wait_counter.sv
// Saturating CPU wait counter with synchronous clear; flags when the limit is reached.
module vram_wait_counter #(
  parameter int unsigned MaxWait = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [7:0] Limit = 8'(MaxWait);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (inc_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == Limit);

endmodule

// File: rtl/vram_arbiter.sv
// Display/CPU arbiter for the single-port video SRAM. Define VRAM_STARVE_GUARD_EN to let a
// CPU that has waited MAX_WAIT cycles pre-empt display; otherwise display has absolute priority.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W   = VramAddrW,
  parameter int unsigned DATA_W   = VramDataW,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we_n,
  output logic              mem_oe_n,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q;
  owner_e            rd_owner_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, disp_rdata_q, cpu_rdata_q;
  logic              mem_we_n_q, mem_oe_n_q, mem_wdata_oe_q;
  logic              disp_rvalid_q, cpu_rvalid_q;
  logic              at_limit;

`ifdef VRAM_STARVE_GUARD_EN
  vram_wait_counter #(
    .MaxWait(MAX_WAIT)
  ) u_wait_counter (
    .clk_i     (clk_25m),
    .rst_ni    (rst_n),
    .inc_i     (cpu_req && !cpu_ack),
    .clr_i     (!cpu_req || cpu_ack),
    .at_limit_o(at_limit)
  );
`else
  assign at_limit = 1'b0;
`endif

  always_comb begin
    disp_ack = 1'b0;
    cpu_ack  = 1'b0;
    if (rst_n && (state_q != StTurn)) begin
      if (cpu_req && at_limit) begin
        cpu_ack = 1'b1;
      end else if (disp_req) begin
        disp_ack = 1'b1;
      end else if (cpu_req) begin
        cpu_ack = 1'b1;
      end
    end
  end

  // A write is driven during TURN itself, so the pins are idle again when the next grant lands.
  always_ff @(posedge clk_25m) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      rd_owner_q     <= OwnNone;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_we_n_q     <= 1'b1;
      mem_oe_n_q     <= 1'b1;
      mem_wdata_oe_q <= 1'b0;
      disp_rvalid_q  <= 1'b0;
      cpu_rvalid_q   <= 1'b0;
      disp_rdata_q   <= '0;
      cpu_rdata_q    <= '0;
    end else begin
      mem_we_n_q     <= 1'b1;
      mem_oe_n_q     <= 1'b1;
      mem_wdata_oe_q <= 1'b0;
      rd_owner_q     <= OwnNone;
      disp_rvalid_q  <= 1'b0;
      cpu_rvalid_q   <= 1'b0;

      if (disp_ack) begin
        state_q    <= StDisp;
        mem_addr_q <= disp_addr;
        mem_oe_n_q <= 1'b0;
        rd_owner_q <= OwnDisp;
      end else if (cpu_ack) begin
        mem_addr_q <= cpu_addr;
        if (cpu_we) begin
          state_q        <= StTurn;
          mem_we_n_q     <= 1'b0;
          mem_wdata_q    <= cpu_wdata;
          mem_wdata_oe_q <= 1'b1;
        end else begin
          state_q    <= StCpu;
          mem_oe_n_q <= 1'b0;
          rd_owner_q <= OwnCpu;
        end
      end else begin
        state_q <= StIdle;
      end

      if (rd_owner_q == OwnDisp) begin
        disp_rvalid_q <= 1'b1;
        disp_rdata_q  <= mem_rdata;
      end else if (rd_owner_q == OwnCpu) begin
        cpu_rvalid_q <= 1'b1;
        cpu_rdata_q  <= mem_rdata;
      end
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_we_n     = mem_we_n_q;
  assign mem_oe_n     = mem_oe_n_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wdata_oe = mem_wdata_oe_q;
  assign disp_rvalid  = disp_rvalid_q;
  assign disp_rdata   = disp_rdata_q;
  assign cpu_rvalid   = cpu_rvalid_q;
  assign cpu_rdata    = cpu_rdata_q;

endmodule
